// File: rtl/multicycle_controller.sv
// Multicycle ARM control unit: Moore main FSM, ALU/immediate decode,
// NZCV flag register and the condition check that gates every
// architectural write (register file, PC, memory, flags).
module multicycle_controller #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ALUControl
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BRANCH
    } state_t;

    state_t      r_state, w_next;
    logic [3:0]  r_flags;          // {N,Z,C,V}

    logic [3:0]  w_cond;
    logic [1:0]  w_op;
    logic [3:0]  w_cmd;
    logic        w_immf, w_sbit, w_rd15;
    logic        w_condex;
    logic        w_n, w_z, w_c, w_v;
    logic        w_legal, w_arith;
    logic [1:0]  w_aluop;
    logic        w_flag_we;

    assign w_cond = Instr[31:28];
    assign w_op   = Instr[27:26];
    assign w_immf = Instr[25];
    assign w_cmd  = Instr[24:21];
    assign w_sbit = Instr[20];
    assign w_rd15 = (Instr[15:12] == 4'hF);
    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Register-port and immediate selects come straight from the opcode
    assign RegSrc = {w_op == 2'b01, w_op == 2'b10};
    assign ImmSrc = w_op;

    // Condition check against the current architectural flags
    always_comb begin
        w_condex = 1'b0;
        case (w_cond)
            4'b0000: w_condex = w_z;
            4'b0001: w_condex = ~w_z;
            4'b0010: w_condex = w_c;
            4'b0011: w_condex = ~w_c;
            4'b0100: w_condex = w_n;
            4'b0101: w_condex = ~w_n;
            4'b0110: w_condex = w_v;
            4'b0111: w_condex = ~w_v;
            4'b1000: w_condex = w_c & ~w_z;
            4'b1001: w_condex = ~w_c | w_z;
            4'b1010: w_condex = (w_n == w_v);
            4'b1011: w_condex = (w_n != w_v);
            4'b1100: w_condex = ~w_z & (w_n == w_v);
            4'b1101: w_condex = w_z | (w_n != w_v);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;   // 1111 never executes
        endcase
    end

    // Data-processing command decode; unknown commands fall back to ADD
    // and are barred from touching the flags
    always_comb begin
        w_aluop = 2'b00;
        w_legal = 1'b1;
        w_arith = 1'b0;
        case (w_cmd)
            4'b0100: begin w_aluop = 2'b00; w_arith = 1'b1; end
            4'b0010: begin w_aluop = 2'b01; w_arith = 1'b1; end
            4'b0000: w_aluop = 2'b10;
            4'b1100: w_aluop = 2'b11;
            default: w_legal = 1'b0;
        endcase
    end

    assign w_flag_we = ((r_state == S_EXECR) || (r_state == S_EXECI)) &&
                       w_sbit && w_condex && w_legal;

    // State register; async reset aborts any in-flight instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Flag register: N,Z on any flag-setting op, C,V only for ADD/SUB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= RESET_FLAGS;
        end else if (w_flag_we) begin
            r_flags[3:2] <= ALUFlags[3:2];
            if (w_arith) r_flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Next-state and Moore outputs; writes are qualified by the condition
    always_comb begin
        w_next     = S_FETCH;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'd0;
        ALUSrcB    = 2'd0;
        ResultSrc  = 2'd0;
        ALUControl = 2'b00;
        case (r_state)
            S_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                w_next  = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = 2'd1;
                ALUSrcB = 2'd2;
                case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_immf ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'd1;
                w_next  = w_sbit ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                w_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'd2;
                RegWrite  = w_condex;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = w_condex;
            end
            S_EXECR: begin
                ALUControl = w_aluop;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'd1;
                ALUControl = w_aluop;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = 2'd1;
                RegWrite  = w_condex;
                PCWrite   = w_condex & w_rd15;
            end
            S_BRANCH: begin
                ALUSrcB = 2'd1;
                PCWrite = w_condex;
            end
            default: w_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instructions cycle by
// cycle and compares the full control word against hand-derived values.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

    int total = 0;
    int bad   = 0;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .IRWrite(IRWrite), .AdrSrc(AdrSrc), .RegSrc(RegSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    logic [16:0] outs;
    assign outs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                   ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

    function automatic logic [16:0] pk(input bit pcw, mw, rw, irw, adr,
                                       input logic [1:0] rs, a, b, res, imm, alu);
        return {pcw, mw, rw, irw, adr, rs, a, b, res, imm, alu};
    endfunction

    // FETCH / DECODE words for a given opcode
    function automatic logic [16:0] fe(input logic [1:0] op);
        return pk(1, 0, 0, 1, 0, {op == 2'b01, op == 2'b10}, 1, 2, 0, op, 0);
    endfunction
    function automatic logic [16:0] de(input logic [1:0] op);
        return pk(0, 0, 0, 0, 0, {op == 2'b01, op == 2'b10}, 1, 2, 0, op, 0);
    endfunction

    localparam logic [31:0] LDR   = 32'hE5901004;
    localparam logic [31:0] ADDS  = 32'hE0902001;
    localparam logic [31:0] SUBS  = 32'hE0502001;
    localparam logic [31:0] BEQ   = 32'h0A000002;
    localparam logic [31:0] BNE   = 32'h1A000000;
    localparam logic [31:0] BCS   = 32'h2A000000;
    localparam logic [31:0] BMI   = 32'h4A000000;
    localparam logic [31:0] STR   = 32'hE5803000;
    localparam logic [31:0] STRNE = 32'h15803000;
    localparam logic [31:0] STRNV = 32'hF5803000;
    localparam logic [31:0] ORRPC = 32'hE380F008;
    localparam logic [31:0] ANDS  = 32'hE2100001;
    localparam logic [31:0] EORS  = 32'hE0302001;
    localparam logic [31:0] NOP3  = 32'hEC000000;

    // Shared per-instruction words
    logic [16:0] w_memadr, w_memrd, w_memwb, w_memwr, w_memwr0;
    logic [16:0] w_exadd, w_exsub, w_aluwb, w_br1, w_br0;
    initial begin
        w_memadr = pk(0, 0, 0, 0, 0, 2, 0, 1, 0, 1, 0);
        w_memrd  = pk(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0);
        w_memwb  = pk(0, 0, 1, 0, 0, 2, 0, 0, 2, 1, 0);
        w_memwr  = pk(0, 1, 0, 0, 1, 2, 0, 0, 0, 1, 0);
        w_memwr0 = pk(0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0);
        w_exadd  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        w_exsub  = pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        w_aluwb  = pk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        w_br1    = pk(1, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0);
        w_br0    = pk(0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 0);
    end

    task automatic test_reset();
        reset = 1'b1; Instr = 32'h0; ALUFlags = 4'h0;
        @(negedge clk); @(negedge clk);
        #1;
        total++;
        if (outs !== fe(2'b00)) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", outs, fe(2'b00));
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ldr();
        logic [31:0] iv[$]; logic [3:0] fv[$]; logic [16:0] ev[$];
        iv = '{LDR, LDR, LDR, LDR, LDR};
        fv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ev = '{fe(1), de(1), w_memadr, w_memrd, w_memwb};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; ALUFlags = fv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL ldr cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_adds_beq();
        logic [31:0] iv[$]; logic [3:0] fv[$]; logic [16:0] ev[$];
        iv = '{ADDS, ADDS, ADDS, ADDS, BEQ, BEQ, BEQ};
        fv = '{4'h6, 4'h6, 4'h6, 4'h6, 4'h0, 4'h0, 4'h0};
        ev = '{fe(0), de(0), w_exadd, w_aluwb, fe(2), de(2), w_br1};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; ALUFlags = fv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL adds_beq cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_beq_not_taken();
        logic [31:0] iv[$]; logic [3:0] fv[$]; logic [16:0] ev[$];
        iv = '{SUBS, SUBS, SUBS, SUBS, BEQ, BEQ, BEQ, NOP3, NOP3};
        fv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ev = '{fe(0), de(0), w_exsub, w_aluwb, fe(2), de(2), w_br0, fe(3), de(3)};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; ALUFlags = fv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL beq_not_taken cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_str();
        logic [31:0] iv[$]; logic [3:0] fv[$]; logic [16:0] ev[$];
        iv = '{STR, STR, STR, STR, ADDS, ADDS, ADDS, ADDS,
               STRNE, STRNE, STRNE, STRNE, STRNV, STRNV, STRNV, STRNV};
        fv = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h4, 4'h4, 4'h4,
               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ev = '{fe(1), de(1), w_memadr, w_memwr, fe(0), de(0), w_exadd, w_aluwb,
               fe(1), de(1), w_memadr, w_memwr0, fe(1), de(1), w_memadr, w_memwr0};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; ALUFlags = fv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL str cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_orr_pc();
        logic [31:0] iv[$]; logic [16:0] ev[$];
        iv = '{ORRPC, ORRPC, ORRPC, ORRPC};
        ev = '{fe(0), de(0), pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3),
               pk(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0)};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; ALUFlags = 4'h0; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL orr_pc cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    // ANDS must leave C alone: flags go 0010 -> 0110
    task automatic test_ands_keeps_c();
        logic [31:0] iv[$]; logic [3:0] fv[$]; logic [16:0] ev[$];
        iv = '{ADDS, ADDS, ADDS, ADDS, ANDS, ANDS, ANDS, ANDS,
               BCS, BCS, BCS, BNE, BNE, BNE};
        fv = '{4'h2, 4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h4,
               4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ev = '{fe(0), de(0), w_exadd, w_aluwb,
               fe(0), de(0), pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2), w_aluwb,
               fe(2), de(2), w_br1, fe(2), de(2), w_br0};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; ALUFlags = fv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL ands_keeps_c cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    // Unlisted cmd with S=1: ADD on the ALU, flags stay 0110
    task automatic test_illegal_cmd();
        logic [31:0] iv[$]; logic [3:0] fv[$]; logic [16:0] ev[$];
        iv = '{EORS, EORS, EORS, EORS, BMI, BMI, BMI, BEQ, BEQ, BEQ};
        fv = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        ev = '{fe(0), de(0), w_exadd, w_aluwb, fe(2), de(2), w_br0, fe(2), de(2), w_br1};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; ALUFlags = fv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL illegal_cmd cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    // Reset during MEMREAD: immediate FETCH, no write-back, flags cleared
    task automatic test_reset_mid();
        logic [31:0] iv[$]; logic [16:0] ev[$];
        iv = '{LDR, LDR, LDR, LDR};
        ev = '{fe(1), de(1), w_memadr, w_memrd};
        ALUFlags = 4'h0;
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            if (k < iv.size() - 1) @(negedge clk);
        end
        #1 reset = 1'b1;
        #1; total++;
        if (outs !== fe(1)) begin
            bad++; $display("FAIL reset_mid_async got=%h exp=%h", outs, fe(1));
        end
        @(negedge clk); #1; total++;
        if (outs !== fe(1)) begin
            bad++; $display("FAIL reset_mid_hold got=%h exp=%h", outs, fe(1));
        end
        @(negedge clk);
        reset = 1'b0;
        iv = '{BEQ, BEQ, BEQ, NOP3};
        ev = '{fe(2), de(2), w_br0, fe(3)};
        for (int k = 0; k < iv.size(); k++) begin
            Instr = iv[k]; #1; total++;
            if (outs !== ev[k]) begin
                bad++; $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", k, outs, ev[k]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_adds_beq();
        test_beq_not_taken();
        test_str();
        test_orr_pc();
        test_ands_keeps_c();
        test_illegal_cmd();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
